bcd_seg_scanner: RTL and testbench

BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

---
 rtl/bcd_seg_pkg.sv | 22 ++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/bcd_seg_scanner.sv | 116 +++++++++++
 tb/tb_bcd_seg_scanner.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared constants for the multiplexed BCD seven-segment scanner.
// Segment patterns are active-high, bit0 = a .. bit6 = g.
package bcd_seg_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD-to-seven-segment decoder; codes 10..15 go dark and raise err_o.
module bcd_to_7seg
    import bcd_seg_pkg::*;
(
    input  logic [BCD_W-1:0] code_i,
    output seg_t             seg_o,
    output logic             err_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        err_o = 1'b0;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed scanner driving NUM_DIGITS BCD decades onto one seven-segment bus.
// Optional leading-zero blanking is compiled in with macro BCD_SCAN_LZB_EN.
module bcd_seg_scanner
    import bcd_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
)
(
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    output logic [SEG_W-1:0]              seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          err
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [BCD_W*NUM_DIGITS-1:0] snap_q;
    logic [PW-1:0]               presc_q, presc_d;
    logic [IW-1:0]               idx_q, idx_d;
    seg_t                        seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        err_q, err_d;

    logic [BCD_W-1:0] dig [NUM_DIGITS];
    logic [BCD_W-1:0] cur_dig;
    seg_t             dec_seg;
    logic             dec_err;
    logic             tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign dig[gi]  = snap_q[gi*BCD_W +: BCD_W];
            assign an_d[gi] = (idx_q == IW'(gi));
        end
    endgenerate

    assign cur_dig = dig[idx_q];
    assign tick    = en && (presc_q == PRESC_MAX);

    bcd_to_7seg u_dec (
        .code_i (cur_dig),
        .seg_o  (dec_seg),
        .err_o  (dec_err)
    );

`ifdef BCD_SCAN_LZB_EN
    // zero_from[i]: decade i and every more-significant decade are zero.
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  blank;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_from[gi] = (dig[gi] == '0);
            end else begin : g_mid
                assign zero_from[gi] = (dig[gi] == '0) && zero_from[gi+1];
            end
        end
    endgenerate

    assign blank = (idx_q != '0) && zero_from[idx_q];
    assign seg_d = blank ? SEG_BLANK : dec_seg;
    assign err_d = blank ? 1'b0 : dec_err;
`else
    assign seg_d = dec_seg;
    assign err_d = dec_err;
`endif

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (en) begin
            if (tick) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Outputs decode the pre-edge index and snapshot, so a load coinciding with a tick shows both changes together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (load) begin
                snap_q <= digits_in;
            end
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with NUM_DIGITS=4, SCAN_DIV=4; expected
// segment tables are hand-written per loaded value (BCD_SCAN_LZB_EN selects the blanked variants).
module tb_bcd_seg_scanner;

    localparam int ND = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;

    bcd_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .seg       (seg),
        .an        (an),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int en_cnt   = 0;

    logic [6:0] cur_seg [ND];
    logic       cur_err [ND];
    logic [6:0] new_seg [ND];
    logic       new_err [ND];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // s = {slot3, slot2, slot1, slot0} seven-bit patterns; e = per-slot err.
    task automatic set_new(input logic [27:0] s, input logic [3:0] e);
        for (int i = 0; i < ND; i++) begin
            new_seg[i] = s[i*7 +: 7];
            new_err[i] = e[i];
        end
    endtask

    task automatic take_new();
        for (int i = 0; i < ND; i++) begin
            cur_seg[i] = new_seg[i];
            cur_err[i] = new_err[i];
        end
    endtask

    // Called at a falling edge: drive inputs, cross one rising edge, check at the next falling edge.
    task automatic step(input logic e, input logic l, input logic [15:0] d);
        int         idx;
        logic [3:0] exp_an;
        en = e;
        load = l;
        digits_in = d;
        @(negedge clk);
        cyc++;
        idx = (en_cnt / SD) % ND;
        exp_an = 4'b0001 << idx;
        $display("cyc %0d en=%0b load=%0b an=%b seg=%h err=%0b", cyc, e, l, an, seg, err);
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("seg", 32'(seg), 32'(cur_seg[idx]));
        check_eq("err", 32'(err), 32'(cur_err[idx]));
        if (e) en_cnt++;
        if (l) take_new();
    endtask

    task automatic load_zero_table();
`ifdef BCD_SCAN_LZB_EN
        set_new({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
`else
        set_new({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
`endif
        take_new();
    endtask

    initial begin
        load_zero_table();

        #1 rstn = 1'b0;
        #2;
        check_eq("rst_seg", 32'(seg), 32'h00);
        check_eq("rst_an", 32'(an), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        check_eq("rst_hold_an", 32'(an), 32'h0);
        check_eq("rst_hold_seg", 32'(seg), 32'h00);

        // Release reset and load 0x1234; first edge still shows the zero snapshot.
        rstn = 1'b1;
        set_new({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);
        step(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 16'h0000);

        // Now mid-slot with an=0100; freeze for 10 cycles, then resume.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0000);

        // Non-BCD decade 1 (0xA).
`ifdef BCD_SCAN_LZB_EN
        set_new({7'h00, 7'h00, 7'h00, 7'h6D}, 4'b0010);
`else
        set_new({7'h3F, 7'h3F, 7'h00, 7'h6D}, 4'b0010);
`endif
        step(1'b1, 1'b1, 16'h00A5);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0000);

        // Leading zeros in decades 3 and 2.
`ifdef BCD_SCAN_LZB_EN
        set_new({7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000);
`else
        set_new({7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b0000);
`endif
        step(1'b1, 1'b1, 16'h0050);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 16'h0000);

        // Asynchronous reset between clock edges.
        #2 rstn = 1'b0;
        #1;
        check_eq("mid_rst_seg", 32'(seg), 32'h00);
        check_eq("mid_rst_an", 32'(an), 32'h0);
        check_eq("mid_rst_err", 32'(err), 32'h0);
        @(negedge clk);
        check_eq("mid_rst_hold_an", 32'(an), 32'h0);
        rstn = 1'b1;
        en_cnt = 0;
        load_zero_table();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000);
        set_new({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);
        step(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
